// File: rtl/cluster_data_demux_pkg.sv
// Shared types and constants for the cluster data-port demultiplexer.
// Holds the address-rule type, the error-response data word and a default rule set.
package cluster_data_demux_pkg;

    // Rules are stored at a fixed width; designs compare their own address against the low bits.
    localparam int unsigned RULE_ADDR_W = 64;

    typedef struct packed {
        logic [RULE_ADDR_W-1:0] base;
        logic [RULE_ADDR_W-1:0] mask;
    } addr_rule_t;

    localparam logic [31:0] CLUSTER_DEMUX_ERR_DATA = 32'hBADACCE5;

    localparam int unsigned NUM_DEFAULT_RULES = 3;

    // Index 0: TCDM, 1: peripherals, 2: external (upper half of the map).
    localparam addr_rule_t [NUM_DEFAULT_RULES-1:0] CLUSTER_DEFAULT_RULES = '{
        '{base: 64'h0000_0000_8000_0000, mask: 64'h0000_0000_8000_0000},
        '{base: 64'h0000_0000_1020_0000, mask: 64'h0000_0000_FFE0_0000},
        '{base: 64'h0000_0000_1000_0000, mask: 64'h0000_0000_FFE0_0000}
    };

    function automatic logic rule_hit(addr_rule_t rule, logic [RULE_ADDR_W-1:0] addr);
        return (addr & rule.mask) == rule.base;
    endfunction

endpackage

// File: rtl/cluster_data_demux_addr_decode.sv
// Combinational address-rule matcher: lowest-index hitting rule wins,
// no hit selects the error target (index NumTargets).
module cluster_data_demux_addr_decode
    import cluster_data_demux_pkg::*;
#(
    parameter int unsigned NumTargets = 4,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned SelWidth   = $clog2(NumTargets + 1),
    parameter addr_rule_t [NumTargets-1:0] AddrRules = '0
) (
    input  logic [AddrWidth-1:0] addr,
    output logic [SelWidth-1:0]  sel,
    output logic                 hit
);

    always_comb begin
        sel = SelWidth'(NumTargets);
        hit = 1'b0;
        // Walk downwards so the lowest matching index is the one left standing.
        for (int i = int'(NumTargets) - 1; i >= 0; i--) begin
            if (rule_hit(AddrRules[i], RULE_ADDR_W'(addr))) begin
                sel = SelWidth'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cluster_data_demux.sv
// N-target core data-port demultiplexer with an internal error responder.
// In-order responses are kept by never switching target while requests are outstanding.
module cluster_data_demux
    import cluster_data_demux_pkg::*;
#(
    parameter int unsigned NumTargets     = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter addr_rule_t [NumTargets-1:0] AddrRules = '0,
    parameter logic [31:0] ErrData        = CLUSTER_DEMUX_ERR_DATA
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             req_i,
    input  logic [AddrWidth-1:0]             add_i,
    input  logic                             we_i,
    input  logic [DataWidth-1:0]             data_i,
    input  logic [DataWidth/8-1:0]           be_i,
    output logic                             gnt_o,
    output logic                             r_valid_o,
    output logic [DataWidth-1:0]             r_data_o,
    output logic                             err_o,
    output logic [NumTargets-1:0]            tgt_req_o,
    output logic [AddrWidth-1:0]             tgt_add_o,
    output logic                             tgt_we_o,
    output logic [DataWidth-1:0]             tgt_data_o,
    output logic [DataWidth/8-1:0]           tgt_be_o,
    input  logic [NumTargets-1:0]            tgt_gnt_i,
    input  logic [NumTargets-1:0]            tgt_r_valid_i,
    input  logic [NumTargets*DataWidth-1:0]  tgt_r_data_i,
    output logic                             busy_o,
    output logic                             unexp_rsp_o
);

    localparam int unsigned SelWidth = $clog2(NumTargets + 1);
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [SelWidth-1:0]  ERR_SEL   = SelWidth'(NumTargets);
    localparam logic [CntWidth-1:0]  CNT_MAX   = CntWidth'(MaxOutstanding);
    localparam logic [DataWidth-1:0] ERR_RDATA = DataWidth'(ErrData);

    logic [SelWidth-1:0]  sel;
    logic                 hit;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [CntWidth-1:0]  err_pend_q, err_pend_d;
    logic [SelWidth-1:0]  last_q;
    logic [NumTargets:0]  rsp_valid;
    logic [DataWidth-1:0] rsp_data;
    logic                 retire, cnt_free, issue_ok, tgt_gnt_sel, accept;

    cluster_data_demux_addr_decode #(
        .NumTargets (NumTargets),
        .AddrWidth  (AddrWidth),
        .SelWidth   (SelWidth),
        .AddrRules  (AddrRules)
    ) u_addr_decode (
        .addr (add_i),
        .sel  (sel),
        .hit  (hit)
    );

    assign tgt_add_o  = add_i;
    assign tgt_we_o   = we_i;
    assign tgt_data_o = data_i;
    assign tgt_be_o   = be_i;
    assign busy_o     = (cnt_q != '0);

    // Request path: a retire this cycle frees a slot and, when it is the last one, allows a switch.
    always_comb begin
        rsp_valid   = {(err_pend_q != '0), tgt_r_valid_i};
        retire      = (cnt_q != '0) && rsp_valid[last_q];
        cnt_free    = (cnt_q == '0) || ((cnt_q == CntWidth'(1)) && retire);
        issue_ok    = !rst_i && (cnt_free || (sel == last_q)) && ((cnt_q < CNT_MAX) || retire);
        tgt_gnt_sel = 1'b0;
        tgt_req_o   = '0;
        for (int t = 0; t < int'(NumTargets); t++) begin
            if (sel == SelWidth'(t)) begin
                tgt_gnt_sel  = tgt_gnt_i[t];
                tgt_req_o[t] = req_i && issue_ok;
            end
        end
        gnt_o  = req_i && issue_ok && (hit ? tgt_gnt_sel : 1'b1);
        accept = gnt_o;
    end

    // Response path: zero-latency mux from the target that owns the in-flight requests.
    always_comb begin
        rsp_data    = '0;
        unexp_rsp_o = 1'b0;
        for (int t = 0; t < int'(NumTargets); t++) begin
            if (last_q == SelWidth'(t)) begin
                rsp_data = tgt_r_data_i[t*DataWidth +: DataWidth];
            end
            if (tgt_r_valid_i[t] && ((last_q != SelWidth'(t)) || (cnt_q == '0))) begin
                unexp_rsp_o = !rst_i;
            end
        end
        if (last_q == ERR_SEL) begin
            rsp_data = ERR_RDATA;
        end
        r_valid_o = retire;
        r_data_o  = retire ? rsp_data : '0;
        err_o     = retire && (last_q == ERR_SEL);
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({accept, retire})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
        // The error responder answers every accepted request exactly one cycle later.
        err_pend_d = err_pend_q;
        if (accept && !hit) begin
            err_pend_d = err_pend_d + CntWidth'(1);
        end
        if (err_pend_q != '0) begin
            err_pend_d = err_pend_d - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            err_pend_q <= '0;
            last_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            err_pend_q <= err_pend_d;
            if (accept) begin
                last_q <= sel;
            end
        end
    end

    cnt_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(accept && !retire && (cnt_q == CNT_MAX)));
    cnt_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(retire && !accept && (cnt_q == '0)));

endmodule

// File: tb/tb_cluster_data_demux.sv
// Self-checking bench for cluster_data_demux: scenario tasks plus a response scoreboard
// fed at every accepted request and drained at every forwarded response.
module tb_cluster_data_demux;
    import cluster_data_demux_pkg::*;

    localparam int NT = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    // T0: TCDM, T1: peripherals, T2: external, T3: extra window.
    localparam addr_rule_t [NT-1:0] RULES = '{
        '{base: 64'h2000_0000, mask: 64'hF000_0000},
        '{base: 64'h8000_0000, mask: 64'hC000_0000},
        '{base: 64'h1020_0000, mask: 64'hFFE0_0000},
        '{base: 64'h1000_0000, mask: 64'hFFE0_0000}
    };

    localparam logic [31:0] A0 = 32'h1000_0010;
    localparam logic [31:0] A1 = 32'h1020_0004;
    localparam logic [31:0] A2 = 32'h8000_0100;
    localparam logic [31:0] A3 = 32'h2000_0040;
    localparam logic [31:0] AU = 32'hF000_0000;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              req_i;
    logic [AW-1:0]     add_i;
    logic              we_i;
    logic [DW-1:0]     data_i;
    logic [DW/8-1:0]   be_i;
    logic              gnt_o;
    logic              r_valid_o;
    logic [DW-1:0]     r_data_o;
    logic              err_o;
    logic [NT-1:0]     tgt_req_o;
    logic [AW-1:0]     tgt_add_o;
    logic              tgt_we_o;
    logic [DW-1:0]     tgt_data_o;
    logic [DW/8-1:0]   tgt_be_o;
    logic [NT-1:0]     tgt_gnt_i;
    logic [NT-1:0]     tgt_r_valid_i;
    logic [NT*DW-1:0]  tgt_r_data_i;
    logic              busy_o;
    logic              unexp_rsp_o;

    always #5 clk = ~clk;

    cluster_data_demux #(
        .NumTargets     (NT),
        .AddrWidth      (AW),
        .DataWidth      (DW),
        .MaxOutstanding (MO),
        .AddrRules      (RULES),
        .ErrData        (32'hBADACCE5)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .add_i         (add_i),
        .we_i          (we_i),
        .data_i        (data_i),
        .be_i          (be_i),
        .gnt_o         (gnt_o),
        .r_valid_o     (r_valid_o),
        .r_data_o      (r_data_o),
        .err_o         (err_o),
        .tgt_req_o     (tgt_req_o),
        .tgt_add_o     (tgt_add_o),
        .tgt_we_o      (tgt_we_o),
        .tgt_data_o    (tgt_data_o),
        .tgt_be_o      (tgt_be_o),
        .tgt_gnt_i     (tgt_gnt_i),
        .tgt_r_valid_i (tgt_r_valid_i),
        .tgt_r_data_i  (tgt_r_data_i),
        .busy_o        (busy_o),
        .unexp_rsp_o   (unexp_rsp_o)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] tgt_q[NT][$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] seq      = 32'd0;

    function automatic int model_decode(logic [31:0] a);
        if ((a & 32'hFFE0_0000) == 32'h1000_0000) return 0;
        if ((a & 32'hFFE0_0000) == 32'h1020_0000) return 1;
        if ((a & 32'hC000_0000) == 32'h8000_0000) return 2;
        if ((a & 32'hF000_0000) == 32'h2000_0000) return 3;
        return NT;
    endfunction

    // Pops on every forwarded response, pushes on every handshake.
    task automatic sb_sample();
        exp_t e;
        int   t;
        if (r_valid_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_rsp_unexpected: r_data_o=%h but no response expected", r_data_o);
            end else begin
                e = exp_q.pop_front();
                if (r_data_o !== e.data || err_o !== e.err) begin
                    n_fail++;
                    $display("FAIL sb_rsp: got data=%h err=%b, expected data=%h err=%b",
                             r_data_o, err_o, e.data, e.err);
                end
            end
        end
        if (req_i && gnt_o) begin
            t = model_decode(add_i);
            if (t == NT) begin
                e.data = 32'hBADACCE5;
                e.err  = 1'b1;
            end else begin
                seq    = seq + 32'd1;
                e.data = 32'hCAFE_0000 + seq;
                e.err  = 1'b0;
                tgt_q[t].push_back(e.data);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        req_i         = 1'b0;
        add_i         = '0;
        we_i          = 1'b0;
        data_i        = '0;
        be_i          = '0;
        tgt_gnt_i     = '0;
        tgt_r_valid_i = '0;
        tgt_r_data_i  = '0;
    endtask

    task automatic settle();
        #1;
        sb_sample();
    endtask

    task automatic issue(input logic [31:0] a, input logic [NT-1:0] g);
        req_i     = 1'b1;
        add_i     = a;
        we_i      = 1'b0;
        data_i    = 32'h1234_5678;
        be_i      = '1;
        tgt_gnt_i = g;
    endtask

    task automatic respond(input int t);
        tgt_r_valid_i[t] = 1'b1;
        if (tgt_q[t].size() > 0) tgt_r_data_i[t*DW +: DW] = tgt_q[t].pop_front();
    endtask

    task automatic test_reset();
        next_cycle();
        settle();
        n_checks++; if (gnt_o !== 1'b0)       begin n_fail++; $display("FAIL reset_gnt: gnt_o=%b expected 0", gnt_o); end
        n_checks++; if (r_valid_o !== 1'b0)   begin n_fail++; $display("FAIL reset_rvalid: r_valid_o=%b expected 0", r_valid_o); end
        n_checks++; if (r_data_o !== '0)      begin n_fail++; $display("FAIL reset_rdata: r_data_o=%h expected 0", r_data_o); end
        n_checks++; if (err_o !== 1'b0)       begin n_fail++; $display("FAIL reset_err: err_o=%b expected 0", err_o); end
        n_checks++; if (unexp_rsp_o !== 1'b0) begin n_fail++; $display("FAIL reset_unexp: unexp_rsp_o=%b expected 0", unexp_rsp_o); end
        n_checks++; if (tgt_req_o !== '0)     begin n_fail++; $display("FAIL reset_tgt_req: tgt_req_o=%b expected 0", tgt_req_o); end
        n_checks++; if (busy_o !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: busy_o=%b expected 0", busy_o); end
        next_cycle();
        rst_i = 1'b0;
        settle();
    endtask

    task automatic test_single_read();
        next_cycle();
        issue(A1, 4'b0010);
        settle();
        n_checks++; if (tgt_req_o !== 4'b0010) begin n_fail++; $display("FAIL single_tgt_req: tgt_req_o=%b expected 0010", tgt_req_o); end
        n_checks++; if (gnt_o !== 1'b1)        begin n_fail++; $display("FAIL single_gnt: gnt_o=%b expected 1", gnt_o); end
        n_checks++; if (tgt_add_o !== A1)      begin n_fail++; $display("FAIL single_add: tgt_add_o=%h expected %h", tgt_add_o, A1); end
        next_cycle();
        settle();
        n_checks++; if (busy_o !== 1'b1)       begin n_fail++; $display("FAIL single_busy: busy_o=%b expected 1", busy_o); end
        n_checks++; if (r_valid_o !== 1'b0)    begin n_fail++; $display("FAIL single_early: r_valid_o=%b expected 0", r_valid_o); end
        next_cycle();
        respond(1);
        settle();
        n_checks++; if (r_valid_o !== 1'b1)    begin n_fail++; $display("FAIL single_rvalid: r_valid_o=%b expected 1", r_valid_o); end
        n_checks++; if (r_data_o !== 32'hCAFE0001) begin n_fail++; $display("FAIL single_rdata: r_data_o=%h expected cafe0001", r_data_o); end
        next_cycle();
        settle();
        n_checks++; if (busy_o !== 1'b0)       begin n_fail++; $display("FAIL single_idle: busy_o=%b expected 0", busy_o); end
    endtask

    task automatic test_outstanding();
        for (int k = 0; k < MO; k++) begin
            next_cycle();
            issue(A0, 4'b0001);
            settle();
            n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL outst_gnt%0d: gnt_o=%b expected 1", k, gnt_o); end
        end
        next_cycle();
        issue(A0, 4'b0001);
        settle();
        n_checks++; if (gnt_o !== 1'b0)     begin n_fail++; $display("FAIL outst_full_gnt: gnt_o=%b expected 0", gnt_o); end
        n_checks++; if (tgt_req_o !== '0)   begin n_fail++; $display("FAIL outst_full_req: tgt_req_o=%b expected 0000", tgt_req_o); end
        next_cycle();
        issue(A0, 4'b0001);
        respond(0);
        settle();
        n_checks++; if (gnt_o !== 1'b1)     begin n_fail++; $display("FAIL outst_retire_gnt: gnt_o=%b expected 1", gnt_o); end
        n_checks++; if (r_valid_o !== 1'b1) begin n_fail++; $display("FAIL outst_retire_rvalid: r_valid_o=%b expected 1", r_valid_o); end
        for (int k = 0; k < MO; k++) begin
            next_cycle();
            respond(0);
            settle();
            n_checks++; if (r_valid_o !== 1'b1) begin n_fail++; $display("FAIL outst_drain%0d: r_valid_o=%b expected 1", k, r_valid_o); end
        end
        next_cycle();
        settle();
        n_checks++; if (busy_o !== 1'b0)    begin n_fail++; $display("FAIL outst_idle: busy_o=%b expected 0", busy_o); end
    endtask

    task automatic test_target_switch();
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            issue(A0, 4'b0001);
            settle();
        end
        next_cycle();
        issue(A2, 4'b0100);
        settle();
        n_checks++; if (gnt_o !== 1'b0 || tgt_req_o !== '0) begin n_fail++; $display("FAIL switch_stall0: gnt_o=%b tgt_req_o=%b expected 0/0000", gnt_o, tgt_req_o); end
        next_cycle();
        issue(A2, 4'b0100);
        respond(0);
        settle();
        n_checks++; if (gnt_o !== 1'b0)     begin n_fail++; $display("FAIL switch_stall1: gnt_o=%b expected 0", gnt_o); end
        n_checks++; if (r_valid_o !== 1'b1) begin n_fail++; $display("FAIL switch_rsp1: r_valid_o=%b expected 1", r_valid_o); end
        next_cycle();
        issue(A2, 4'b0100);
        respond(0);
        settle();
        n_checks++; if (gnt_o !== 1'b1)        begin n_fail++; $display("FAIL switch_gnt: gnt_o=%b expected 1", gnt_o); end
        n_checks++; if (tgt_req_o !== 4'b0100) begin n_fail++; $display("FAIL switch_req: tgt_req_o=%b expected 0100", tgt_req_o); end
        next_cycle();
        respond(2);
        settle();
        n_checks++; if (r_valid_o !== 1'b1) begin n_fail++; $display("FAIL switch_rsp2: r_valid_o=%b expected 1", r_valid_o); end
        next_cycle();
        settle();
        n_checks++; if (busy_o !== 1'b0)    begin n_fail++; $display("FAIL switch_idle: busy_o=%b expected 0", busy_o); end
    endtask

    task automatic test_unmapped();
        next_cycle();
        issue(AU, 4'b0000);
        settle();
        n_checks++; if (gnt_o !== 1'b1)     begin n_fail++; $display("FAIL unmap_gnt: gnt_o=%b expected 1", gnt_o); end
        n_checks++; if (tgt_req_o !== '0)   begin n_fail++; $display("FAIL unmap_tgt_req: tgt_req_o=%b expected 0000", tgt_req_o); end
        n_checks++; if (r_valid_o !== 1'b0) begin n_fail++; $display("FAIL unmap_early: r_valid_o=%b expected 0", r_valid_o); end
        next_cycle();
        settle();
        n_checks++; if (r_valid_o !== 1'b1 || err_o !== 1'b1) begin n_fail++; $display("FAIL unmap_rsp: r_valid_o=%b err_o=%b expected 1/1", r_valid_o, err_o); end
        next_cycle();
        settle();
        n_checks++; if (r_valid_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL unmap_after: r_valid_o=%b err_o=%b busy_o=%b expected 0/0/0", r_valid_o, err_o, busy_o); end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        issue(AU, 4'b0000);
        settle();
        next_cycle();
        issue(AU, 4'b0000);
        settle();
        n_checks++; if (gnt_o !== 1'b1 || err_o !== 1'b1) begin n_fail++; $display("FAIL b2b_err2: gnt_o=%b err_o=%b expected 1/1", gnt_o, err_o); end
        next_cycle();
        issue(A3, 4'b1000);
        settle();
        n_checks++; if (gnt_o !== 1'b1 || tgt_req_o !== 4'b1000) begin n_fail++; $display("FAIL b2b_switch: gnt_o=%b tgt_req_o=%b expected 1/1000", gnt_o, tgt_req_o); end
        n_checks++; if (err_o !== 1'b1)     begin n_fail++; $display("FAIL b2b_err_last: err_o=%b expected 1", err_o); end
        next_cycle();
        respond(3);
        settle();
        n_checks++; if (r_valid_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("FAIL b2b_t3: r_valid_o=%b err_o=%b expected 1/0", r_valid_o, err_o); end
        next_cycle();
        settle();
        n_checks++; if (busy_o !== 1'b0)    begin n_fail++; $display("FAIL b2b_idle: busy_o=%b expected 0", busy_o); end
    endtask

    task automatic test_spurious();
        next_cycle();
        issue(A0, 4'b0001);
        settle();
        next_cycle();
        tgt_r_valid_i[3] = 1'b1;
        tgt_r_data_i[3*DW +: DW] = 32'hDEAD_0003;
        settle();
        n_checks++; if (unexp_rsp_o !== 1'b1) begin n_fail++; $display("FAIL spur_other_unexp: unexp_rsp_o=%b expected 1", unexp_rsp_o); end
        n_checks++; if (r_valid_o !== 1'b0)   begin n_fail++; $display("FAIL spur_other_rvalid: r_valid_o=%b expected 0", r_valid_o); end
        next_cycle();
        respond(0);
        settle();
        n_checks++; if (r_valid_o !== 1'b1 || unexp_rsp_o !== 1'b0) begin n_fail++; $display("FAIL spur_real: r_valid_o=%b unexp_rsp_o=%b expected 1/0", r_valid_o, unexp_rsp_o); end
        next_cycle();
        tgt_r_valid_i[0] = 1'b1;
        tgt_r_data_i[0 +: DW] = 32'hDEAD_0000;
        settle();
        n_checks++; if (unexp_rsp_o !== 1'b1 || r_valid_o !== 1'b0) begin n_fail++; $display("FAIL spur_idle: unexp_rsp_o=%b r_valid_o=%b expected 1/0", unexp_rsp_o, r_valid_o); end
        next_cycle();
        settle();
        n_checks++; if (unexp_rsp_o !== 1'b0) begin n_fail++; $display("FAIL spur_clear: unexp_rsp_o=%b expected 0", unexp_rsp_o); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            issue(A1, 4'b0010);
            settle();
        end
        next_cycle();
        rst_i = 1'b1;
        issue(A1, 4'b0010);
        tgt_r_valid_i[1] = 1'b1;
        tgt_r_data_i[1*DW +: DW] = 32'hCAFE_00FF;
        settle();
        n_checks++; if (busy_o !== 1'b0)      begin n_fail++; $display("FAIL rmid_busy: busy_o=%b expected 0", busy_o); end
        n_checks++; if (gnt_o !== 1'b0 || tgt_req_o !== '0) begin n_fail++; $display("FAIL rmid_req: gnt_o=%b tgt_req_o=%b expected 0/0000", gnt_o, tgt_req_o); end
        n_checks++; if (r_valid_o !== 1'b0 || r_data_o !== '0 || err_o !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp: r_valid_o=%b r_data_o=%h err_o=%b expected 0/0/0", r_valid_o, r_data_o, err_o); end
        n_checks++; if (unexp_rsp_o !== 1'b0) begin n_fail++; $display("FAIL rmid_unexp: unexp_rsp_o=%b expected 0", unexp_rsp_o); end
        exp_q.delete();
        for (int t = 0; t < NT; t++) tgt_q[t].delete();
        next_cycle();
        rst_i = 1'b0;
        tgt_r_valid_i[1] = 1'b1;
        tgt_r_data_i[1*DW +: DW] = 32'hCAFE_00FE;
        settle();
        n_checks++; if (unexp_rsp_o !== 1'b1) begin n_fail++; $display("FAIL rmid_late_unexp: unexp_rsp_o=%b expected 1", unexp_rsp_o); end
        n_checks++; if (r_valid_o !== 1'b0)   begin n_fail++; $display("FAIL rmid_late_rvalid: r_valid_o=%b expected 0", r_valid_o); end
        next_cycle();
        settle();
        n_checks++; if (unexp_rsp_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: unexp_rsp_o=%b busy_o=%b expected 0/0", unexp_rsp_o, busy_o); end
    endtask

    initial begin
        rst_i         = 1'b1;
        req_i         = 1'b0;
        add_i         = '0;
        we_i          = 1'b0;
        data_i        = '0;
        be_i          = '0;
        tgt_gnt_i     = '0;
        tgt_r_valid_i = '0;
        tgt_r_data_i  = '0;
        test_reset();
        test_single_read();
        test_outstanding();
        test_target_switch();
        test_unmapped();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d responses still expected, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1, "watchdog expired");
    end

endmodule
